// File: rtl/sha3_digest_serializer.sv
// rtl/sha3_digest_serializer.sv - streams the SHA3-512 digest lanes of the final Keccak state as WORD_W-bit words
// Optional SHA3_DIGEST_BYTESWAP_EN: reverse bytes within each output word (FIPS 202 printed order).
module sha3_digest_serializer #(
    parameter int WORD_W   = 64,
    parameter int DIGEST_W = 512
) (
    input  logic              inClk,
    input  logic              inRstN,
    input  logic [1599:0]     inState,
    input  logic              inStateValid,
    output logic              outStateReady,
    output logic [WORD_W-1:0] outWord,
    output logic              outWordValid,
    input  logic              inWordReady,
    output logic              outLast,
    output logic              outBusy
);

    localparam int NWORDS = DIGEST_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DIGEST_W-1:0] digest;
    logic [WORD_W-1:0]   laneWord;
    logic [WORD_W-1:0]   orderedWord;
    logic                xfer;
    logic                isLast;

    // Only the digest lanes matter; the rest of the state is intentionally dropped.
    logic unusedStateBits;
    assign unusedStateBits = ^inState[1599:DIGEST_W];

    assign xfer     = outWordValid && inWordReady;
    assign isLast   = (state == SEND) && (cnt == LAST_CNT);
    assign laneWord = digest[WORD_W*int'(cnt) +: WORD_W];

`ifdef SHA3_DIGEST_BYTESWAP_EN
    for (genvar g = 0; g < WORD_W/8; g++) begin : gSwap
        assign orderedWord[g*8 +: 8] = laneWord[WORD_W-8-g*8 +: 8];
    end
`else
    assign orderedWord = laneWord;
`endif

    // Gated so the idle output is zero rather than a stale digest word.
    assign outWord = outWordValid ? orderedWord : '0;
    assign outLast = isLast;

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state         <= IDLE;
            cnt           <= '0;
            digest        <= '0;
            outStateReady <= 1'b0;
            outWordValid  <= 1'b0;
            outBusy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    outStateReady <= 1'b1;
                    if (inStateValid && outStateReady) begin
                        digest        <= inState[DIGEST_W-1:0];
                        cnt           <= '0;
                        state         <= SEND;
                        outStateReady <= 1'b0;
                        outWordValid  <= 1'b1;
                        outBusy       <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (isLast) begin
                            cnt           <= '0;
                            state         <= IDLE;
                            outStateReady <= 1'b1;
                            outWordValid  <= 1'b0;
                            outBusy       <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// tb/tb_sha3_digest_serializer.sv - randomized self-checking bench for sha3_digest_serializer
module tb_sha3_digest_serializer;

    logic          inClk = 1'b0;
    logic          inRstN;
    logic [1599:0] inState;
    logic          inStateValid;
    logic          outStateReady;
    logic [63:0]   outWord;
    logic          outWordValid;
    logic          inWordReady;
    logic          outLast;
    logic          outBusy;

    int totalCnt = 0;
    int badCnt   = 0;

    localparam logic [511:0] EMPTY_HEX =
        512'ha69f73cca23a9ac5c8b567dc185a756e97c982164fe25859e0d1dcc1475c80a615b2123af1f5f94c11e3e9402c3ac558f500199d95b6d3e301758586281dcd26;

    sha3_digest_serializer dut (
        .inClk         (inClk),
        .inRstN        (inRstN),
        .inState       (inState),
        .inStateValid  (inStateValid),
        .outStateReady (outStateReady),
        .outWord       (outWord),
        .outWordValid  (outWordValid),
        .inWordReady   (inWordReady),
        .outLast       (outLast),
        .outBusy       (outBusy)
    );

    always #5 inClk = ~inClk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    function automatic logic [1599:0] randState();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // Word k is made of digest bytes 8k..8k+7 (byte n = state bits [8n+7:8n]).
    function automatic logic [63:0] modelWord(input logic [1599:0] st, input int k);
        logic [63:0] w;
        logic [7:0]  b;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            b = st[(k*8 + j)*8 +: 8];
`ifdef SHA3_DIGEST_BYTESWAP_EN
            w[(7-j)*8 +: 8] = b;
`else
            w[j*8 +: 8] = b;
`endif
        end
        return w;
    endfunction

    task automatic runDigest(input logic [1599:0] st, input bit randReady, input string tag);
        logic [63:0] exp [8];
        logic [63:0] prevWord;
        bit          stalled;
        int          got;
        int          cyc;
        for (int k = 0; k < 8; k++) exp[k] = modelWord(st, k);
        check({tag, ".readyBefore"}, 64'(outStateReady), 64'd1);
        inState      = st;
        inStateValid = 1'b1;
        tick();
        inStateValid = 1'b0;
        inState      = randState();
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        prevWord = '0;
        while (got < 8 && cyc < 400) begin
            inWordReady = randReady ? 1'($urandom % 2) : 1'b1;
            if (stalled) check({tag, ".stable"}, outWord, prevWord);
            if (!outWordValid) begin
                check({tag, ".valid"}, 64'(outWordValid), 64'd1);
                break;
            end
            if (inWordReady) begin
                check($sformatf("%s.word%0d", tag, got), outWord, exp[got]);
                check($sformatf("%s.last%0d", tag, got), 64'(outLast), 64'(got == 7));
                check($sformatf("%s.busy%0d", tag, got), 64'(outBusy), 64'd1);
                got++;
                stalled = 1'b0;
            end else begin
                prevWord = outWord;
                stalled  = 1'b1;
            end
            tick();
            cyc++;
        end
        inWordReady = 1'b0;
        check({tag, ".count"}, 64'(got), 64'd8);
        if (!randReady) check({tag, ".cycles"}, 64'(cyc), 64'd8);
        check({tag, ".readyAfter"}, 64'(outStateReady), 64'd1);
        check({tag, ".validAfter"}, 64'(outWordValid), 64'd0);
        check({tag, ".busyAfter"}, 64'(outBusy), 64'd0);
    endtask

    initial begin
        logic [1599:0] st;
        logic [1599:0] stA;
        logic [1599:0] stB;

        // Reset held with a valid state presented.
        inRstN       = 1'b0;
        inStateValid = 1'b1;
        inState      = randState();
        inWordReady  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.valid", 64'(outWordValid), 64'd0);
            check("rst.busy", 64'(outBusy), 64'd0);
            check("rst.ready", 64'(outStateReady), 64'd0);
            check("rst.word", outWord, 64'd0);
        end
        inRstN       = 1'b1;
        inStateValid = 1'b0;
        inWordReady  = 1'b0;
        check("rel.readyNoEdge", 64'(outStateReady), 64'd0);
        tick();
        check("rel.ready", 64'(outStateReady), 64'd1);
        check("rel.valid", 64'(outWordValid), 64'd0);

        // Empty-message digest, sink always ready.
        st = randState();
        for (int i = 0; i < 64; i++) st[i*8 +: 8] = EMPTY_HEX[511 - 8*i -: 8];
`ifdef SHA3_DIGEST_BYTESWAP_EN
        check("empty.word0Const", modelWord(st, 0), 64'ha69f73cca23a9ac5);
`else
        check("empty.word0Const", modelWord(st, 0), 64'hc59a3aa2cc739fa6);
`endif
        runDigest(st, 1'b0, "empty");

        // Lane k holds k, random backpressure.
        st = randState();
        for (int k = 0; k < 8; k++) st[k*64 +: 64] = 64'(k);
        runDigest(st, 1'b1, "bp");

        // Second state presented while busy must be ignored.
        stA = randState();
        stB = randState();
        inState      = stA;
        inStateValid = 1'b1;
        tick();
        inStateValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            inWordReady = 1'b1;
            if (k >= 2 && k <= 4) begin
                inState      = stB;
                inStateValid = 1'b1;
                check("busy.stateReady", 64'(outStateReady), 64'd0);
            end else begin
                inStateValid = 1'b0;
            end
            check($sformatf("busy.word%0d", k), outWord, modelWord(stA, k));
            tick();
        end
        inStateValid = 1'b0;
        inWordReady  = 1'b0;
        tick();
        check("busy.idleValid", 64'(outWordValid), 64'd0);
        runDigest(stB, 1'b1, "second");

        // Reset in the middle of a digest after word 3 is accepted.
        st = randState();
        inState      = st;
        inStateValid = 1'b1;
        tick();
        inStateValid = 1'b0;
        inWordReady  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mid.word%0d", k), outWord, modelWord(st, k));
            tick();
        end
        inRstN = 1'b0;
        #1;
        check("mid.valid", 64'(outWordValid), 64'd0);
        check("mid.busy", 64'(outBusy), 64'd0);
        check("mid.last", 64'(outLast), 64'd0);
        check("mid.word", outWord, 64'd0);
        check("mid.ready", 64'(outStateReady), 64'd0);
        tick();
        inRstN      = 1'b1;
        inWordReady = 1'b0;
        tick();
        check("mid.relReady", 64'(outStateReady), 64'd1);
        check("mid.relValid", 64'(outWordValid), 64'd0);

        // Random digests with random backpressure.
        for (int n = 0; n < 6; n++) runDigest(randState(), 1'b1, $sformatf("rnd%0d", n));

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
